// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage.
//   fetch_state_e : fetch FSM state encodings
//   NOP_INSTR     : instruction word loaded into IF/ID as a bubble
//   pc_plus4      : sequential PC increment (wraps modulo 2^32)
package fetch_stage_pkg;

    typedef enum logic {
        StFetch = 1'b0,
        StHold  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
//   clk, reset_n          : clock, asynchronous active-low reset
//   en                    : load in_pc4/in_instr/in_valid
//   flush                 : load a bubble; takes priority over en
//   in_pc4/in_instr/in_valid : next contents
//   pc4/instr/valid       : registered contents
module ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] in_pc4,
    input  logic [31:0] in_instr,
    input  logic        in_valid,
    output logic [31:0] pc4,
    output logic [31:0] instr,
    output logic        valid
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc4   <= 32'h0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (flush) begin
            pc4   <= 32'h0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (en) begin
            pc4   <= in_pc4;
            instr <= in_instr;
            valid <= in_valid;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with wait-state memory handshake and a one-entry skid buffer.
//   clk, reset_n                         : clock, asynchronous active-low reset
//   PC_WriteEn, IFID_WriteEn, Stall_flush : hazard controls
//   branch_taken, branch_target          : redirect from ID (highest priority)
//   imem_addr, imem_req, imem_ready, imem_rdata : instruction memory interface
//   IFID_PC4, IFID_Instr, IFID_valid     : IF/ID pipeline register
//   fetch_stall, stall_cnt               : memory-wait indicator and saturating wait count
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PC_WriteEn,
    input  logic        IFID_WriteEn,
    input  logic        Stall_flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IFID_PC4,
    output logic [31:0] IFID_Instr,
    output logic        IFID_valid,
    output logic        fetch_stall,
    output logic [15:0] stall_cnt
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  pc4;
    logic [31:0]  skid_pc4;
    logic [31:0]  skid_instr;
    logic         in_fetch;
    logic         advance;
    logic         fetch_hit;
    logic         load_data;
    logic         ifid_flush;
    logic [31:0]  ifid_pc4_in;
    logic [31:0]  ifid_instr_in;

    assign pc4       = pc_plus4(pc);
    assign in_fetch  = (state == StFetch);
    assign advance   = PC_WriteEn & IFID_WriteEn & ~branch_taken;
    assign fetch_hit = in_fetch & imem_ready;

    // Memory is idle while reset is held, so gate the request with reset_n.
    assign imem_req    = reset_n & in_fetch;
    assign imem_addr   = pc;
    assign fetch_stall = reset_n & in_fetch & ~imem_ready;

    // A real word enters IF/ID only when the pipe advances and no flush is requested;
    // any other enabled write (or a redirect) inserts a bubble.
    assign load_data     = advance & ~Stall_flush & (fetch_hit | (state == StHold));
    assign ifid_flush    = branch_taken | (IFID_WriteEn & ~load_data);
    assign ifid_pc4_in   = (state == StHold) ? skid_pc4   : pc4;
    assign ifid_instr_in = (state == StHold) ? skid_instr : imem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StFetch;
            pc         <= RESET_PC;
            skid_pc4   <= 32'h0;
            skid_instr <= NOP_INSTR;
        end else if (branch_taken) begin
            // Any response in this cycle and any parked word are dropped.
            state      <= StFetch;
            pc         <= branch_target;
            skid_pc4   <= 32'h0;
            skid_instr <= NOP_INSTR;
        end else begin
            unique case (state)
                StFetch: begin
                    if (imem_ready) begin
                        if (advance) begin
                            pc <= pc4;
                        end else begin
                            skid_pc4   <= pc4;
                            skid_instr <= imem_rdata;
                            state      <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (advance) begin
                        pc         <= pc4;
                        skid_pc4   <= 32'h0;
                        skid_instr <= NOP_INSTR;
                        state      <= StFetch;
                    end
                end
                default: state <= StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 16'h0;
        end else if (fetch_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (load_data),
        .flush    (ifid_flush),
        .in_pc4   (ifid_pc4_in),
        .in_instr (ifid_instr_in),
        .in_valid (1'b1),
        .pc4      (IFID_PC4),
        .instr    (IFID_Instr),
        .valid    (IFID_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. Memory returns {16'hA5A5, addr[15:0]}.
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        PC_WriteEn;
    logic        IFID_WriteEn;
    logic        Stall_flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IFID_PC4;
    logic [31:0] IFID_Instr;
    logic        IFID_valid;
    logic        fetch_stall;
    logic [15:0] stall_cnt;

    int compared;
    int mismatched;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .PC_WriteEn    (PC_WriteEn),
        .IFID_WriteEn  (IFID_WriteEn),
        .Stall_flush   (Stall_flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .IFID_PC4      (IFID_PC4),
        .IFID_Instr    (IFID_Instr),
        .IFID_valid    (IFID_valid),
        .fetch_stall   (fetch_stall),
        .stall_cnt     (stall_cnt)
    );

    assign imem_rdata = {16'hA5A5, imem_addr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc4, input logic [31:0] ins,
                            input logic vld);
        chk({tag, ".pc4"},   IFID_PC4,   pc4);
        chk({tag, ".instr"}, IFID_Instr, ins);
        chk({tag, ".valid"}, {31'h0, IFID_valid}, {31'h0, vld});
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        reset_n       = 1'b0;
        PC_WriteEn    = 1'b1;
        IFID_WriteEn  = 1'b1;
        Stall_flush   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ready    = 1'b1;

        // Reset state
        step();
        step();
        chk("rst.req", {31'h0, imem_req}, 32'h0);
        chk("rst.cnt", {16'h0, stall_cnt}, 32'h0);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);

        reset_n = 1'b1;
        #1;
        chk("rel.req", {31'h0, imem_req}, 32'h1);
        chk("rel.addr", imem_addr, 32'h0);

        // Streaming fetch: 4, 8, 12
        step();
        chk_ifid("seq0", 32'd4, 32'hA5A5_0000, 1'b1);
        chk("seq0.addr", imem_addr, 32'd4);
        step();
        chk_ifid("seq1", 32'd8, 32'hA5A5_0004, 1'b1);
        step();
        chk_ifid("seq2", 32'd12, 32'hA5A5_0008, 1'b1);
        chk("seq2.addr", imem_addr, 32'd12);

        // Redirect back to 8
        branch_taken  = 1'b1;
        branch_target = 32'h8;
        step();
        branch_taken  = 1'b0;
        chk_ifid("br8", 32'h0, 32'h0, 1'b0);
        chk("br8.addr", imem_addr, 32'h8);

        // Three wait states at PC=8
        imem_ready = 1'b0;
        #1;
        chk("wait.stall0", {31'h0, fetch_stall}, 32'h1);
        step();
        chk("wait.stall1", {31'h0, fetch_stall}, 32'h1);
        step();
        chk("wait.addr", imem_addr, 32'h8);
        step();
        chk("wait.cnt", {16'h0, stall_cnt}, 32'd3);
        chk("wait.addr2", imem_addr, 32'h8);
        chk_ifid("wait", 32'h0, 32'h0, 1'b0);
        imem_ready = 1'b1;
        #1;
        chk("wait.stall_off", {31'h0, fetch_stall}, 32'h0);
        step();
        chk_ifid("wait.done", 32'd12, 32'hA5A5_0008, 1'b1);
        chk("wait.cnt_hold", {16'h0, stall_cnt}, 32'd3);

        // Load-use stall at PC=12: word parked in skid buffer
        PC_WriteEn   = 1'b0;
        IFID_WriteEn = 1'b0;
        step();
        chk_ifid("hold0", 32'd12, 32'hA5A5_0008, 1'b1);
        chk("hold0.req", {31'h0, imem_req}, 32'h0);
        step();
        chk_ifid("hold1", 32'd12, 32'hA5A5_0008, 1'b1);
        chk("hold1.addr", imem_addr, 32'd12);
        PC_WriteEn   = 1'b1;
        IFID_WriteEn = 1'b1;
        step();
        chk_ifid("unhold", 32'd16, 32'hA5A5_000C, 1'b1);
        chk("unhold.addr", imem_addr, 32'd16);
        chk("unhold.req", {31'h0, imem_req}, 32'h1);
        step();
        chk_ifid("resume", 32'd20, 32'hA5A5_0010, 1'b1);

        // Branch while in HOLD (PC_WriteEn=0 too): buffer dropped
        PC_WriteEn   = 1'b0;
        IFID_WriteEn = 1'b0;
        step();
        chk("hold2.req", {31'h0, imem_req}, 32'h0);
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        PC_WriteEn   = 1'b1;
        IFID_WriteEn = 1'b1;
        chk_ifid("brhold", 32'h0, 32'h0, 1'b0);
        chk("brhold.addr", imem_addr, 32'h40);
        step();
        chk_ifid("br40", 32'h44, 32'hA5A5_0040, 1'b1);

        // Stall_flush: bubble, PC still advances
        Stall_flush = 1'b1;
        step();
        Stall_flush = 1'b0;
        chk_ifid("flush", 32'h0, 32'h0, 1'b0);
        chk("flush.addr", imem_addr, 32'h48);
        step();
        chk_ifid("postflush", 32'h4C, 32'hA5A5_0048, 1'b1);

        // PC wrap
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk_ifid("wrap", 32'h0, 32'hA5A5_FFFC, 1'b1);
        chk("wrap.next", imem_addr, 32'h0);

        // IFID_WriteEn=0 holds IF/ID even with Stall_flush=1
        IFID_WriteEn = 1'b0;
        Stall_flush  = 1'b1;
        step();
        chk_ifid("lu_flush", 32'h0, 32'hA5A5_FFFC, 1'b1);
        IFID_WriteEn = 1'b1;
        Stall_flush  = 1'b0;
        step();
        chk_ifid("lu_release", 32'd4, 32'hA5A5_0000, 1'b1);
        chk("lu_release.addr", imem_addr, 32'd4);

        // Reset pulse mid-wait
        imem_ready = 1'b0;
        step();
        chk("mid.cnt", {16'h0, stall_cnt}, 32'd4);
        #2;
        reset_n = 1'b0;
        #1;
        chk_ifid("async", 32'h0, 32'h0, 1'b0);
        chk("async.req", {31'h0, imem_req}, 32'h0);
        chk("async.cnt", {16'h0, stall_cnt}, 32'h0);
        imem_ready = 1'b1;
        step();
        reset_n = 1'b1;
        #1;
        chk("rerel.addr", imem_addr, 32'h0);
        chk_ifid("rerel", 32'h0, 32'h0, 1'b0);
        step();
        chk_ifid("rerel.first", 32'd4, 32'hA5A5_0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
